// File: rtl/stream_width_packer_pkg.sv
// Shared stream helpers: lane-mask function, index-width helper and the
// packed-lane typedef pattern used by width-converting stream stages.
package stream_pkg;

    localparam int MAX_RATIO    = 32;
    localparam int DEF_IN_WIDTH = 8;
    localparam int DEF_RATIO    = 4;

    // Width of a lane index for a given ratio; never collapses to zero bits.
    function automatic int idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Lanes 0..idx set, everything above cleared: (1 << (idx+1)) - 1.
    function automatic logic [MAX_RATIO-1:0] keep_mask(input int unsigned idx);
        logic [MAX_RATIO-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_RATIO; i++) begin
            if (i <= idx) m[i] = 1'b1;
        end
        return m;
    endfunction

    typedef logic [DEF_RATIO-1:0][DEF_IN_WIDTH-1:0] lanes_t;

endpackage

// File: rtl/stream_width_packer_if.sv
// Narrow-in / wide-out stream bundle; slave is the packer, master its environment.
interface stream_width_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;

    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [RATIO-1:0]     out_keep;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_keep, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_keep, out_valid
    );
endinterface

// File: rtl/stream_width_packer_out_reg.sv
// Output holding register with valid/ready; load replaces the word, clear flushes it.
module stream_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    // Caller only asserts load when the slot is free or draining this cycle,
    // so a held word is never overwritten.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/stream_width_packer.sv
// Packs RATIO narrow beats (or fewer, on in_last) into one wide word with a lane-keep mask.
module stream_width_packer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clear,
    stream_width_packer_if.slave bus
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int WORD_W    = OUT_WIDTH + RATIO;
    localparam int IDX_W     = idx_w(RATIO);

    typedef logic [RATIO-1:0][IN_WIDTH-1:0] word_lanes_t;

    logic [IDX_W-1:0] idx_q;
    word_lanes_t      acc_q;
    word_lanes_t      acc_nxt;
    logic [RATIO-1:0] keep_nxt;
    logic             in_ready;
    logic             in_hs;
    logic             last_lane;
    logic             complete;
    logic             out_valid;
    logic [WORD_W-1:0] word_q;

    assign in_ready  = !out_valid || bus.out_ready;
    assign in_hs     = bus.in_valid && in_ready;
    assign last_lane = (idx_q == IDX_W'(RATIO - 1));
    assign complete  = in_hs && (last_lane || bus.in_last);
    assign keep_nxt  = RATIO'(keep_mask(32'(idx_q)));

    // Lanes above idx are already zero because the accumulator is cleared
    // on every completion, so the merged value is the finished word as-is.
    always_comb begin
        acc_nxt        = acc_q;
        acc_nxt[idx_q] = bus.in_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q <= '0;
            acc_q <= '0;
        end else if (clear) begin
            idx_q <= '0;
            acc_q <= '0;
        end else if (complete) begin
            idx_q <= '0;
            acc_q <= '0;
        end else if (in_hs) begin
            idx_q <= idx_q + IDX_W'(1);
            acc_q <= acc_nxt;
        end
    end

    stream_out_reg #(
        .WIDTH(WORD_W)
    ) u_out_reg (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (clear),
        .load     (complete),
        .load_data({keep_nxt, acc_nxt}),
        .ready    (bus.out_ready),
        .valid    (out_valid),
        .data     (word_q)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = word_q[OUT_WIDTH-1:0];
    assign bus.out_keep  = word_q[WORD_W-1:OUT_WIDTH];
endmodule

// File: tb/tb_stream_width_packer.sv
// Bench for stream_width_packer: queue-based word model checked every cycle,
// directed scenarios pinned to literal words, then a randomized soak.
module tb_stream_width_packer;
    localparam int IW = 8;
    localparam int R  = 4;
    localparam int OW = IW * R;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    stream_width_packer_if #(.IN_WIDTH(IW), .RATIO(R)) bus();

    stream_width_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
        .clk  (clk),
        .rstn (rstn),
        .clear(clear),
        .bus  (bus)
    );

    typedef struct {
        logic [OW-1:0] data;
        logic [R-1:0]  keep;
        int            cyc;
    } word_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [IW-1:0] pend[$];
    word_t         exp_q[$];
    word_t         dlog[$];
    int            vcnt   = 0;
    int            ir_low = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_log(input string name, input int i, input logic [OW-1:0] d, input logic [R-1:0] k);
        if (i < dlog.size()) begin
            chk({name, "_data"}, 64'(dlog[i].data), 64'(d));
            chk({name, "_keep"}, 64'(dlog[i].keep), 64'(k));
        end else begin
            checks++;
            failures++;
            $display("FAIL %s: word %0d missing, only %0d words delivered", name, i, dlog.size());
        end
    endtask

    // Model: beats collect in pend; a word forms at RATIO beats or on last.
    // At most one formed word may be outstanding, and it is what the DUT shows.
    task automatic monitor();
        logic          hold_prev = 1'b0;
        logic [OW-1:0] data_prev = '0;
        logic [R-1:0]  keep_prev = '0;
        word_t         w;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pend.delete();
                exp_q.delete();
                hold_prev = 1'b0;
            end else begin
                chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
                chk("in_ready", 64'(bus.in_ready), 64'((exp_q.size() == 0) || bus.out_ready));
                if (hold_prev) begin
                    chk("hold_data", 64'(bus.out_data), 64'(data_prev));
                    chk("hold_keep", 64'(bus.out_keep), 64'(keep_prev));
                end
                if (bus.out_valid) vcnt++;
                if (!bus.in_ready) ir_low++;
                if (bus.out_valid && bus.out_ready && !clear && exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    chk("word_data", 64'(bus.out_data), 64'(w.data));
                    chk("word_keep", 64'(bus.out_keep), 64'(w.keep));
                    dlog.push_back('{data: bus.out_data, keep: bus.out_keep, cyc: cyc});
                end
                hold_prev = bus.out_valid && !bus.out_ready && !clear;
                data_prev = bus.out_data;
                keep_prev = bus.out_keep;
                if (clear) begin
                    pend.delete();
                    exp_q.delete();
                end else if (bus.in_valid && bus.in_ready) begin
                    pend.push_back(bus.in_data);
                    if (pend.size() == R || bus.in_last) begin
                        w.data = '0;
                        for (int i = 0; i < pend.size(); i++)
                            w.data = w.data | (OW'(pend[i]) << (IW * i));
                        w.keep = R'((1 << pend.size()) - 1);
                        w.cyc  = cyc;
                        exp_q.push_back(w);
                        pend.delete();
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [IW-1:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: beat %0h never accepted", d);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int v0;
        int ir0;
        int c0;
        fork
            monitor();
        join_none

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_keep", 64'(bus.out_keep), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        @(posedge clk);
        #1;

        // Full word, valid for exactly one cycle
        base = dlog.size();
        v0   = vcnt;
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        idle(4);
        chk("full_count", 64'(dlog.size() - base), 64'd1);
        chk_log("full", base, 32'h44332211, 4'b1111);
        chk("full_valid_cycles", 64'(vcnt - v0), 64'd1);

        // Partial word then full word
        base = dlog.size();
        send(8'hAA, 1'b0); send(8'hBB, 1'b1);
        for (int i = 1; i <= 4; i++) send(IW'(i), 1'b0);
        idle(4);
        chk_log("partial", base, 32'h0000BBAA, 4'b0011);
        chk_log("after_partial", base + 1, 32'h04030201, 4'b1111);

        // Backpressure
        base = dlog.size();
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(IW'(i), 1'b0);
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
                chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
                chk("bp_held_data", 64'(bus.out_data), 64'h04030201);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        idle(4);
        chk("bp_count", 64'(dlog.size() - base), 64'd2);
        chk_log("bp_w0", base, 32'h04030201, 4'b1111);
        chk_log("bp_w1", base + 1, 32'h08070605, 4'b1111);

        // Clear a held word
        base = dlog.size();
        bus.out_ready = 1'b0;
        send(8'h99, 1'b1);
        idle(2);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("clr_out_data", 64'(bus.out_data), 64'd0);
        chk("clr_out_keep", 64'(bus.out_keep), 64'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        // Clear two pending beats while a third is offered
        send(8'h55, 1'b0); send(8'h66, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        clear        = 1'b1;
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("clr2_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(IW'(8'h10 + i), 1'b0);
        idle(4);
        chk("clr_count", 64'(dlog.size() - base), 64'd1);
        chk_log("clr_word", base, 32'h13121110, 4'b1111);

        // Streaming at full rate
        base = dlog.size();
        c0   = cyc;
        ir0  = ir_low;
        for (int i = 0; i < 16; i++) send(IW'(i), 1'b0);
        idle(4);
        chk("stream_count", 64'(dlog.size() - base), 64'd4);
        chk_log("stream_w0", base,     32'h03020100, 4'b1111);
        chk_log("stream_w1", base + 1, 32'h07060504, 4'b1111);
        chk_log("stream_w2", base + 2, 32'h0B0A0908, 4'b1111);
        chk_log("stream_w3", base + 3, 32'h0F0E0D0C, 4'b1111);
        for (int i = 0; i < 4; i++)
            if (base + i < dlog.size())
                chk("stream_cycle", 64'(dlog[base + i].cyc - c0), 64'(4 * (i + 1)));
        chk("stream_in_ready_drops", 64'(ir_low - ir0), 64'd0);

        // Asynchronous reset with a held word and a partial word in flight
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(IW'(i), 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_data", 64'(bus.out_data), 64'd0);
        chk("arst_out_keep", 64'(bus.out_keep), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        base = dlog.size();
        send(8'h21, 1'b1);
        idle(3);
        chk_log("arst_after", base, 32'h00000021, 4'b0001);

        // Randomized soak
        for (int n = 0; n < 3000; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = IW'($urandom);
            bus.in_last   = ($urandom_range(0, 4) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            clear         = ($urandom_range(0, 49) == 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        clear         = 1'b0;
        bus.out_ready = 1'b1;
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stream_width_packer.md
# stream_width_packer

Packs a stream of narrow `IN_WIDTH` beats into `RATIO`-beat wide words ahead of `sync_2t_fifo`, so the FIFO stores one wide entry per `RATIO` input beats. It supports early word termination via `in_last`, and provides a registered output with valid/ready handshake on both sides. It sits directly upstream of the FIFO write port: `out_*` connects to the FIFO's `in_*`, and `clear` is shared with the FIFO.

## Interface
- `IN_WIDTH`, default 8: width of one input beat.
- `RATIO`, default 4: beats per output word; must be ≥ 2.
- `OUT_WIDTH`, default `IN_WIDTH*RATIO`: derived, not overridden.
- `clk`  in  1: single clock, all logic on rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous flush of accumulator and output register.
- `in_data`  in  `IN_WIDTH`: input beat.
- `in_valid`  in  1: input beat valid.
- `in_last`  in  1: beat terminates the current word, even if partial.
- `in_ready`  out  1: block accepts a beat this cycle.
- `out_data`  out  `OUT_WIDTH`: packed word; beat 0 in bits `[IN_WIDTH-1:0]`.
- `out_keep`  out  `RATIO`: lane-valid mask; lane k is valid if bit k is set.
- `out_valid`  out  1: word valid.
- `out_ready`  in  1: downstream accepts the word.

## Operation
- An input handshake occurs when `in_valid && in_ready`. An output handshake occurs when `out_valid && out_ready`.
- `in_ready` = `!out_valid || out_ready`. It is combinational from state and `out_ready` only, never from `in_valid` or `in_last`.
- The accumulator is `RATIO` lanes plus a lane index `idx` (0..`RATIO`-1, width `$clog2(RATIO)`).
  - Each input handshake writes `in_data` into lane `idx`.
- Completing beat: a handshake with `idx == RATIO-1` or with `in_last == 1`. On a completing beat:
  - The output register loads the accumulator lanes 0..`idx`, including the current beat.
  - Lanes above `idx` load as zero.
  - `out_keep` is set to `(1<<(idx+1))-1`.
  - `out_valid` becomes 1.
  - `idx` returns to 0 and the accumulator is zeroed.
- Non-completing beat: `idx` increments and the output register is unchanged.
- `in_last` on lane `RATIO-1` behaves exactly like a full word.
- Output handshake with no completing beat in the same cycle: `out_valid` goes to 0. `out_data` and `out_keep` hold their values, which are don't-care.
- Output handshake and completing beat in the same cycle: the new word loads and `out_valid` stays 1. There is no bubble.
- `clear` takes priority over all handshakes in that cycle:
  - `idx` = 0, accumulator = 0.
  - `out_valid` = 0, `out_data` = 0, `out_keep` = 0.
  - Any beat accepted in that cycle is discarded.
- Values in the output register never change while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_keep` = 0.
  - `idx` = 0, accumulator = 0.
  - `in_ready` = 1 (combinational).
- Reset mid-operation: all state clears immediately on `rstn` falling, with no clock required. Partial words are lost.
- Latency: the word is visible (`out_valid` = 1) on the cycle after the handshake of its completing beat.
- Throughput: 1 beat/cycle sustained while `out_ready` = 1. `in_ready` never drops in that case.
- Backpressure: while a word is held with `out_ready` = 0, `in_ready` = 0. Accumulation pauses, including for non-completing beats.

## Structure
- Shared package `stream_pkg`:
  - `keep_mask(idx)` function.
  - Localparam helper for `IDX_W = $clog2(RATIO)`.
  - Packed-lane typedef pattern for `[RATIO-1:0][IN_WIDTH-1:0]`.
- One sub-module, `stream_out_reg`: the output holding register with valid/ready, load and clear inputs, and a parameterized data width. It is reused later for other stages.
- The accumulator, index counter and completion logic stay in the top module.

## Test plan
Configuration: `IN_WIDTH` = 8, `RATIO` = 4.

1. **Reset:** hold `rstn` = 0 for 10 cycles, then release → `out_valid` = 0, `out_keep` = 0, `in_ready` = 1, `out_data` = 0.
2. **Full word:** push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `out_ready` = 1 → one cycle after the 0x44 handshake, `out_data` = 0x44332211, `out_keep` = 4'b1111, `out_valid` high for exactly 1 cycle.
3. **Partial word:** push 0xAA, then 0xBB with `in_last` = 1 → `out_data` = 0x0000BBAA, `out_keep` = 4'b0011. The next 4 beats 0x01..0x04 give 0x04030201 with `out_keep` = 4'b1111.
4. **Backpressure:** `out_ready` = 0, `in_valid` held with data 0x01..0x08 → after 4 handshakes, `in_ready` = 0 and 0x04030201 is held stable. Raising `out_ready` yields 0x04030201 then 0x08070605, with no loss or duplication.
5. **Clear:** 2 beats pending plus a held word, assert `clear` for 1 cycle → next cycle `out_valid` = 0. Then 0x10..0x13 give exactly 0x13121110 with `out_keep` = 4'b1111.
6. **Streaming:** 16 back-to-back beats 0x00..0x0F with `out_ready` = 1 → 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on cycles 5, 9, 13, 17 after the first beat. `in_ready` is never 0.
